// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the pins, frames 11-bit
// PS/2 words, checks odd parity and stop bit, and presents scan codes.
module ps2_scancode_rx #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT      = 50000,
    parameter int VALID_CYCLES = 4
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       valid_scan_code,
    output logic       parity_err,
    output logic       frame_err
);

    // state    | meaning
    // S_IDLE   | waiting for a start bit (data low on a fall event)
    // S_DATA   | shifting in 8 data bits, LSB first
    // S_PARITY | capturing the odd-parity bit
    // S_STOP   | checking stop bit and parity, then accept or drop
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int VW = $clog2(VALID_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [VW-1:0] VALID_LAST = VW'(VALID_CYCLES - 1);

    logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic          filt_clk_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall_q;
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    scancode_q;
    logic          valid_q;
    logic [VW-1:0] valid_cnt_q;
    logic          parity_err_q, frame_err_q;

    logic filt_switch_d, fall_d, accept_d;

    always_comb begin
        filt_switch_d = (clk_sync_q != filt_clk_q) && (filt_cnt_q == FILT_LAST);
        fall_d        = filt_switch_d && filt_clk_q;
        accept_d      = (state_q == S_STOP) && fall_q && data_sync_q
                        && (^{par_q, shift_q});
    end

    // Two-flop synchronizers; idle bus level is high on both lines.
    always_ff @(posedge reloj) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // The filtered clock follows only after FILTER_LEN consecutive samples at the new level.
    always_ff @(posedge reloj) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= fall_d;
            if (clk_sync_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_switch_d) begin
                filt_clk_q <= clk_sync_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                tmo_cnt_q <= '0;
                if (fall_q && !data_sync_q) begin
                    state_q   <= S_DATA;
                    bit_cnt_q <= '0;
                end
            end else if (fall_q) begin
                tmo_cnt_q <= '0;
                case (state_q)
                    S_DATA: begin
                        shift_q   <= {data_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q   <= data_sync_q;
                        state_q <= S_STOP;
                    end
                    default: begin
                        // A bad stop bit masks any parity verdict.
                        if (!data_sync_q)              frame_err_q  <= 1'b1;
                        else if (!(^{par_q, shift_q})) parity_err_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                endcase
            end else if (tmo_cnt_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                tmo_cnt_q   <= '0;
                state_q     <= S_IDLE;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    // Hold timer is decoupled from the FSM so a new frame can start while valid is high.
    always_ff @(posedge reloj) begin
        if (reset) begin
            scancode_q  <= '0;
            valid_q     <= 1'b0;
            valid_cnt_q <= '0;
        end else if (accept_d) begin
            scancode_q  <= shift_q;
            valid_q     <= 1'b1;
            valid_cnt_q <= VALID_LAST;
        end else if (valid_cnt_q != '0) begin
            valid_cnt_q <= valid_cnt_q - 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign scancode        = scancode_q;
    assign valid_scan_code = valid_q;
    assign parity_err      = parity_err_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed and random PS/2 frames are
// judged by a frame-level model; a monitor compares every DUT output event.
module tb_ps2_scancode_rx;

    localparam int FL   = 8;
    localparam int TMO  = 200;
    localparam int VC   = 4;
    localparam int HALF = 20;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       valid_scan_code, parity_err, frame_err;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO), .VALID_CYCLES(VC)) dut (
        .reloj(reloj), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .valid_scan_code(valid_scan_code),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #10 reloj = ~reloj;

    typedef enum int {K_VALID = 0, K_PERR = 1, K_FERR_STOP = 2, K_FERR_TMO = 3} kind_t;
    typedef struct {kind_t kind; logic [7:0] code;} exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    logic [7:0] model_code = 8'h00;

    always @(posedge reloj) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Frame-level reference: what the receiver should report for this frame.
    task automatic expect_frame(input logic [7:0] code, input logic par, input logic stop,
                                input int nbits);
        exp_t e;
        if (nbits < 11) begin
            e.kind = K_FERR_TMO;
        end else if (!stop) begin
            e.kind = K_FERR_STOP;
        end else if ((($countones(code) + int'(par)) % 2) == 1) begin
            e.kind = K_VALID;
            model_code = code;
        end else begin
            e.kind = K_PERR;
        end
        e.code = model_code;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {stop, par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 3) begin
                repeat (4) @(negedge reloj);
                ps2_clk = 1'b0;
                repeat (3) @(negedge reloj);
                ps2_clk = 1'b1;
                repeat (3) @(negedge reloj);
            end else begin
                repeat (HALF / 2) @(negedge reloj);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge reloj);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge reloj);
        end
        ps2_data = 1'b1;
    endtask

    task automatic idle_glitch();
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge reloj);
        ps2_clk = 1'b1;
        repeat (5) @(negedge reloj);
        ps2_data = 1'b1;
        repeat (20) @(negedge reloj);
    endtask

    task automatic take(input kind_t k);
        exp_t  e;
        kind_t req_k;
        int    off;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0d required=none", int'(k));
        end else begin
            e     = sb.pop_front();
            req_k = (e.kind == K_FERR_TMO) ? K_FERR_STOP : e.kind;
            off   = (e.kind == K_FERR_TMO) ? TMO : 0;
            chk("event_kind", int'(k), int'(req_k));
            chk("scancode", int'(scancode), int'(e.code));
            chk_rng("latency", cyc - last_fall_cyc, off + FL + 2, off + FL + 5);
        end
    endtask

    logic v_prev = 1'b0, pe_prev = 1'b0, fe_prev = 1'b0;
    int   vlen = 0;

    always @(negedge reloj) begin
        if (reset) begin
            v_prev  = 1'b0;
            pe_prev = 1'b0;
            fe_prev = 1'b0;
            vlen    = 0;
        end else begin
            if (valid_scan_code && !v_prev) begin
                vlen = 1;
                take(K_VALID);
            end else if (valid_scan_code) begin
                vlen++;
            end else if (v_prev) begin
                chk("valid_len", vlen, VC);
            end
            if (pe_prev) chk("perr_width", int'(parity_err), 0);
            else if (parity_err) take(K_PERR);
            if (fe_prev) chk("ferr_width", int'(frame_err), 0);
            else if (frame_err) take(K_FERR_STOP);
            v_prev  = valid_scan_code;
            pe_prev = parity_err;
            fe_prev = frame_err;
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_scancode"}, int'(scancode), 0);
        chk({tag, "_valid"}, int'(valid_scan_code), 0);
        chk({tag, "_perr"}, int'(parity_err), 0);
        chk({tag, "_ferr"}, int'(frame_err), 0);
    endtask

    task automatic frame(input logic [7:0] code, input logic par, input logic stop,
                         input int nbits, input bit glitch);
        expect_frame(code, par, stop, nbits);
        send_frame(code, par, stop, nbits, glitch);
        if (nbits < 11) repeat (TMO + 60) @(negedge reloj);
        else repeat (40) @(negedge reloj);
    endtask

    initial begin
        int    sel, nbits;
        logic [7:0] code;
        logic  par, stop;
        repeat (3) @(negedge reloj);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (20) @(negedge reloj);

        frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        idle_glitch();
        frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
        frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);

        // Partial frame cut off by a one-cycle reset: nothing may be reported.
        send_frame(8'h1C, 1'b0, 1'b1, 6, 1'b0);
        repeat (10) @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        check_outputs_zero("midreset");
        reset = 1'b0;
        model_code = 8'h00;
        repeat (20) @(negedge reloj);
        frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);

        for (int r = 0; r < 40; r++) begin
            code  = 8'($urandom);
            par   = ~(^code);
            stop  = 1'b1;
            nbits = 11;
            sel   = $urandom_range(0, 9);
            if (sel == 0) par = ~par;
            if (sel == 1) begin
                stop = 1'b0;
                par  = 1'($urandom);
            end
            if (sel == 2) nbits = $urandom_range(1, 10);
            frame(code, par, stop, nbits, sel == 3);
            repeat ($urandom_range(0, 60)) @(negedge reloj);
        end

        for (int w = 0; w < 2000 && sb.size() != 0; w++) @(negedge reloj);
        chk("sb_drained", sb.size(), 0);
        repeat (20) @(negedge reloj);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before the filtered ps2_clk changes level.
REQ-002 SHALL have parameter TIMEOUT, default 50000: idle reloj cycles inside a frame before the frame is aborted (1 ms at 50 MHz).
REQ-003 SHALL have parameter VALID_CYCLES, default 4: cycles valid_scan_code is held high per accepted code (minimum 2).
REQ-004 SHALL use one clock and a synchronous, active-high reset: ports reloj (50 MHz) and reset.
REQ-005 reloj  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset (pb[0]).
REQ-007 ps2_clk  input  1  raw, asynchronous PS/2 clock pin.
REQ-008 ps2_data  input  1  raw, asynchronous PS/2 data pin.
REQ-009 scancode  output  8  last accepted scan code; stable from the cycle valid_scan_code rises until the next accepted frame.
REQ-010 valid_scan_code  output  1  high for exactly VALID_CYCLES consecutive cycles per accepted code; feeds the scan-code display stage.
REQ-011 parity_err  output  1  one-cycle pulse: frame dropped for bad odd parity.
REQ-012 frame_err  output  1  one-cycle pulse: frame dropped for stop bit = 0 or timeout.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Filtered clock SHALL change to the synchronized level only after FILTER_LEN consecutive cycles at the new level; shorter excursions are ignored.
REQ-015 A falling edge of the filtered clock SHALL produce a one-cycle fall event; synchronized ps2_data SHALL be sampled in that cycle.
REQ-016 FSM states: IDLE, DATA, PARITY, STOP; state changes only on fall events, timeout, or reset.
REQ-017 IDLE: fall event with data=0 (start bit) -> DATA with bit count 0; data=1 -> remain IDLE, no output.
REQ-018 DATA: each fall event shifts data in LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: fall event captures parity bit -> STOP.
REQ-020 STOP: on fall event, if stop=1 and the 9 bits (data+parity) have an odd count of ones, scancode SHALL load and valid_scan_code SHALL rise on the next cycle; FSM -> IDLE.
REQ-021 STOP with bad parity SHALL pulse parity_err, leave scancode unchanged, -> IDLE; stop=0 SHALL pulse frame_err (takes priority over parity_err if both fail; only frame_err pulses), -> IDLE.
REQ-022 valid_scan_code hold counter SHALL run independently of the FSM, so a new start bit is accepted while valid is still high.
REQ-023 A new accepted code arriving while valid is high SHALL reload scancode and restart the VALID_CYCLES count (not observable at default settings; defined for completeness).
REQ-024 Timeout counter SHALL clear on every fall event and in IDLE; in DATA/PARITY/STOP, reaching TIMEOUT cycles without a fall event SHALL pulse frame_err and force IDLE.
REQ-025 Latency from ps2_clk pin falling edge (stop bit) to valid_scan_code rise SHALL be within FILTER_LEN+2 to FILTER_LEN+5 reloj cycles.
REQ-026 Outputs SHALL be registered; no combinational path from pins to outputs.

Reset
REQ-027 On reset: FSM IDLE, bit count 0, shift register 0, timeout/valid/filter counters 0, filtered clock 1, scancode 0x00, valid_scan_code 0, parity_err 0, frame_err 0.
REQ-028 Reset SHALL override every simultaneous event, including a fall event or timeout in the same cycle; a frame interrupted by reset is discarded without error pulses.
REQ-029 After reset, the first accepted frame SHALL require a fresh start bit; bits of an interrupted frame are never reused.

Verification
REQ-030 Frame 0x1C (data 0011_1000 LSB first, parity 0, stop 1) at 12.5 kHz -> scancode=0x1C, valid_scan_code high exactly 4 cycles, no error pulses.
REQ-031 Back-to-back frames 0xF0 (parity 1) then 0x1C -> two valid windows of 4 cycles, scancode 0xF0 then 0x1C.
REQ-032 Frame 0x1C with parity 1 -> one parity_err pulse, valid_scan_code stays 0, scancode retains previous value.
REQ-033 3-cycle low glitches on ps2_clk during idle and mid-frame -> no bit accepted, subsequent 0x1C frame decoded correctly.
REQ-034 Clock stops after 4 data bits -> frame_err pulse TIMEOUT cycles after the last fall, FSM IDLE; following frame 0xF0 accepted.
REQ-035 Reset asserted for one cycle after bit 5 of a frame -> all outputs 0, no error pulse; next complete 0x1C frame accepted.
